onchip_mem_dma: RTL and testbench

Avalon-MM master that moves blocks of 32-bit words into and within the 32K-word single-port on-chip memory. It has two modes: fill, which writes a constant, and copy, which reads from a source and writes to a destination. It drives the memory's slave port, with a 15-bit word address and a 1-cycle read latency. It is commanded by a local start/busy/done interface from the NIOS-side control logic.

---
 rtl/onchip_mem_dma.sv | 191 +++++++++++++++++++
 tb/tb_onchip_mem_dma.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_dma.sv
// onchip_mem_dma
//   Avalon-MM master that fills or copies blocks of 32-bit words in a
//   single-port on-chip memory (1-cycle read latency, no waitrequest).
//   Commanded by a start/busy/done handshake.
//
//   Optional feature macro: ONCHIP_MEM_DMA_CHECKSUM_EN adds a 32-bit
//   running sum (mod 2^32) of every word written by the current command.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   start, mode              command strobe (IDLE only), 0 = fill / 1 = copy
//   src_addr, dst_addr       copy source / destination word addresses
//   length                   word count (0 legal)
//   fill_data                fill pattern
//   busy, done               status and single-cycle completion pulse
//   m_address .. m_clken     Avalon-MM master to the memory slave port
//   checksum                 (macro only) sum of written words
//   m_readdata               memory read data, valid 1 cycle after read
module onchip_mem_dma #(
  parameter int ADDR_W = 15,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [31:0]       fill_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] m_address,
  output logic [3:0]        m_byteenable,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [31:0]       m_writedata,
  output logic              m_clken,
`ifdef ONCHIP_MEM_DMA_CHECKSUM_EN
  output logic [31:0]       checksum,
`endif
  input  logic [31:0]       m_readdata
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FILL = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_LAT  = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]        state;
  logic [ADDR_W-1:0] src_ptr;   // next source address to read
  logic [ADDR_W-1:0] dst_ptr;   // next destination address to write
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt;       // words written so far
  logic              last;

  assign m_clken = 1'b1;

  // The word being written in this cycle is the final one.
  assign last = (cnt + LEN_W'(1)) == len_q;

  // Bus outputs are registered: each state's bus cycle is set up on the
  // edge that enters it. m_writedata doubles as the latched fill pattern
  // (never overwritten during a fill) and as the copy data register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      m_address    <= '0;
      m_byteenable <= '0;
      m_chipselect <= 1'b0;
      m_write      <= 1'b0;
      m_writedata  <= '0;
      src_ptr      <= '0;
      dst_ptr      <= '0;
      len_q        <= '0;
      cnt          <= '0;
`ifdef ONCHIP_MEM_DMA_CHECKSUM_EN
      checksum     <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q <= length;
            cnt   <= '0;
`ifdef ONCHIP_MEM_DMA_CHECKSUM_EN
            checksum <= '0;
`endif
            if (length == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else if (!mode) begin
              state        <= S_FILL;
              busy         <= 1'b1;
              m_address    <= dst_addr;
              dst_ptr      <= dst_addr + ADDR_W'(1);
              m_writedata  <= fill_data;
              m_chipselect <= 1'b1;
              m_write      <= 1'b1;
              m_byteenable <= '1;
            end else begin
              state        <= S_RD;
              busy         <= 1'b1;
              m_address    <= src_addr;
              src_ptr      <= src_addr + ADDR_W'(1);
              dst_ptr      <= dst_addr;
              m_chipselect <= 1'b1;
              m_write      <= 1'b0;
              m_byteenable <= '1;
            end
          end
        end

        S_FILL: begin
          cnt <= cnt + LEN_W'(1);
`ifdef ONCHIP_MEM_DMA_CHECKSUM_EN
          checksum <= checksum + m_writedata;
`endif
          if (last) begin
            state        <= S_DONE;
            done         <= 1'b1;
            busy         <= 1'b0;
            m_chipselect <= 1'b0;
            m_write      <= 1'b0;
            m_byteenable <= '0;
          end else begin
            m_address <= dst_ptr;
            dst_ptr   <= dst_ptr + ADDR_W'(1);
          end
        end

        S_RD: begin
          state        <= S_LAT;
          m_chipselect <= 1'b0;
          m_write      <= 1'b0;
          m_byteenable <= '0;
        end

        S_LAT: begin
          state        <= S_WR;
          m_writedata  <= m_readdata;
          m_address    <= dst_ptr;
          dst_ptr      <= dst_ptr + ADDR_W'(1);
          m_chipselect <= 1'b1;
          m_write      <= 1'b1;
          m_byteenable <= '1;
        end

        S_WR: begin
          cnt <= cnt + LEN_W'(1);
`ifdef ONCHIP_MEM_DMA_CHECKSUM_EN
          checksum <= checksum + m_writedata;
`endif
          if (last) begin
            state        <= S_DONE;
            done         <= 1'b1;
            busy         <= 1'b0;
            m_chipselect <= 1'b0;
            m_write      <= 1'b0;
            m_byteenable <= '0;
          end else begin
            state        <= S_RD;
            m_address    <= src_ptr;
            src_ptr      <= src_ptr + ADDR_W'(1);
            m_chipselect <= 1'b1;
            m_write      <= 1'b0;
            m_byteenable <= '1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state        <= S_IDLE;
          busy         <= 1'b0;
          m_chipselect <= 1'b0;
          m_write      <= 1'b0;
          m_byteenable <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onchip_mem_dma.sv
// tb_onchip_mem_dma
//   Directed and randomized commands for onchip_mem_dma against a word
//   memory attached to its master port and a behavioural reference model
//   that computes expected bus traffic, timing, memory contents and
//   checksum from the command alone.
module tb_onchip_mem_dma;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [14:0] src_addr = '0;
  logic [14:0] dst_addr = '0;
  logic [15:0] length = '0;
  logic [31:0] fill_data = '0;
  logic        busy, done, m_chipselect, m_write, m_clken;
  logic [14:0] m_address;
  logic [3:0]  m_byteenable;
  logic [31:0] m_writedata;
  logic [31:0] rdata = '0;
`ifdef ONCHIP_MEM_DMA_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  onchip_mem_dma #(.ADDR_W(15), .LEN_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .fill_data(fill_data), .busy(busy), .done(done),
    .m_address(m_address), .m_byteenable(m_byteenable),
    .m_chipselect(m_chipselect), .m_write(m_write),
    .m_writedata(m_writedata), .m_clken(m_clken),
`ifdef ONCHIP_MEM_DMA_CHECKSUM_EN
    .checksum(checksum),
`endif
    .m_readdata(rdata)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem   [0:32767];
  logic [31:0] model [0:32767];

  // Slave memory: 1-cycle registered read, write on the access cycle.
  always @(posedge clk) begin
    if (m_chipselect && !m_write) rdata <= mem[m_address];
    if (m_chipselect && m_write)  mem[m_address] = m_writedata;
  end

  typedef struct {
    int          c;
    bit          we;
    int          addr;
    logic [31:0] data;
  } bus_t;

  bus_t bus_q[$];
  bus_t exp_q[$];
  int   be_err = 0;

  always @(negedge clk) begin
    bus_t e;
    if (m_chipselect) begin
      e.c = cyc; e.we = m_write; e.addr = int'(m_address); e.data = m_writedata;
      bus_q.push_back(e);
    end
    if (m_byteenable !== (m_chipselect ? 4'hF : 4'h0)) be_err++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one command at the current negedge and checks it to completion.
  // With poke set, extra starts with other arguments are pulsed two cycles
  // in and during the done cycle; both must be ignored.
  task automatic run_cmd(input bit md, input logic [14:0] s, input logic [14:0] d,
                         input logic [15:0] n, input logic [31:0] fd,
                         input bit poke, input string nm);
    int t0, dcyc, span, a, m;
    logic [31:0] sum, w;
    bus_t e;
    bus_q.delete(); exp_q.delete(); be_err = 0;
    mode = md; src_addr = s; dst_addr = d; length = n; fill_data = fd; start = 1'b1;
    t0 = cyc;
    sum = '0;
    for (int i = 0; i < int'(n); i++) begin
      a = (int'(d) + i) % 32768;
      if (md) begin
        w = model[(int'(s) + i) % 32768];
        e.c = t0 + 1 + 3*i; e.we = 1'b0; e.addr = (int'(s) + i) % 32768; e.data = '0;
        exp_q.push_back(e);
        e.c = t0 + 3 + 3*i; e.we = 1'b1; e.addr = a; e.data = w;
        exp_q.push_back(e);
      end else begin
        w = fd;
        e.c = t0 + 1 + i; e.we = 1'b1; e.addr = a; e.data = w;
        exp_q.push_back(e);
      end
      model[a] = w;
      sum += w;
    end
    span = md ? 3*int'(n) : int'(n);
    @(negedge clk); start = 1'b0;
    check({nm, "_busy_first"}, busy, n != 0);
    dcyc = -1;
    for (int k = 0; k < span + 10 && dcyc < 0; k++) begin
      if (done === 1'b1) dcyc = cyc;
      else begin
        if (poke && cyc == t0 + 2) begin
          start = 1'b1; mode = ~md; src_addr = 15'($urandom); dst_addr = 15'($urandom);
          length = 16'd5; fill_data = $urandom;
        end
        @(negedge clk); start = 1'b0;
      end
    end
    check({nm, "_done_cycle"}, dcyc, t0 + span + 1);
    check({nm, "_busy_at_done"}, busy, 1'b0);
`ifdef ONCHIP_MEM_DMA_CHECKSUM_EN
    check({nm, "_checksum"}, checksum, sum);
`endif
    if (poke) begin
      start = 1'b1; mode = ~md; src_addr = 15'($urandom); dst_addr = 15'($urandom);
      length = 16'd7; fill_data = $urandom;
    end
    @(negedge clk); start = 1'b0;
    check({nm, "_idle_after"}, {busy, done, m_chipselect}, 3'b000);
    check({nm, "_bus_count"}, bus_q.size(), exp_q.size());
    m = (bus_q.size() < exp_q.size()) ? bus_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s_bus%0d_cycle", nm, i), bus_q[i].c, exp_q[i].c);
      check($sformatf("%s_bus%0d_op", nm, i), {bus_q[i].we, bus_q[i].addr}, {exp_q[i].we, exp_q[i].addr});
      if (exp_q[i].we)
        check($sformatf("%s_bus%0d_wdata", nm, i), bus_q[i].data, exp_q[i].data);
    end
    check({nm, "_byteenable"}, be_err, 0);
    foreach (exp_q[i])
      if (exp_q[i].we)
        check($sformatf("%s_mem_%0h", nm, exp_q[i].addr), mem[exp_q[i].addr], model[exp_q[i].addr]);
  endtask

  logic        r_md;
  logic [14:0] r_s, r_d;
  logic [15:0] r_n;
  int          t_rst;

  initial begin
    for (int i = 0; i < 32768; i++) begin
      mem[i] = $urandom;
      model[i] = mem[i];
    end
    #3;
    check("reset_outputs", {busy, done, m_chipselect, m_write, m_address, m_byteenable, m_writedata}, '0);
    check("clken_tied", m_clken, 1'b1);
`ifdef ONCHIP_MEM_DMA_CHECKSUM_EN
    check("reset_checksum", checksum, 32'h0);
`endif
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    run_cmd(1'b0, 15'h0, 15'h0010, 16'd4, 32'hA5A5_5A5A, 1'b0, "fill");

    for (int i = 0; i < 3; i++) begin
      mem[32'h100 + i] = 32'(i + 1);
      model[32'h100 + i] = 32'(i + 1);
    end
    run_cmd(1'b1, 15'h0100, 15'h0200, 16'd3, 32'h0, 1'b0, "copy");
    check("copy_word2", mem[32'h202], 32'd3);

    run_cmd(1'b0, 15'h0, 15'h7FFE, 16'd3, $urandom, 1'b0, "wrap");
    run_cmd(1'b0, 15'h0, 15'h1234, 16'd0, $urandom, 1'b0, "zero");
    run_cmd(1'b1, 15'h0300, 15'h0400, 16'd2, 32'h0, 1'b1, "busy");
    run_cmd(1'b0, 15'h0, 15'h0500, 16'd2, 32'h1234_5678, 1'b0, "next_idle");
    run_cmd(1'b1, 15'h0600, 15'h0602, 16'd6, 32'h0, 1'b0, "overlap");
    run_cmd(1'b1, 15'h7FFD, 15'h0010, 16'd4, 32'h0, 1'b0, "src_wrap");

    for (int r = 0; r < 8; r++) begin
      r_md = 1'($urandom);
      r_s  = 15'($urandom);
      r_d  = 15'($urandom);
      r_n  = 16'($urandom_range(0, 12));
      run_cmd(r_md, r_s, r_d, r_n, $urandom, 1'b0, $sformatf("rand%0d", r));
    end

    // Reset during the write of word 5 of a 10-word copy.
    mode = 1'b1; src_addr = 15'h0700; dst_addr = 15'h0800; length = 16'd10; start = 1'b1;
    t_rst = cyc;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 40 && cyc < t_rst + 15; k++) @(negedge clk);
    check("rst_in_wr", {m_chipselect, m_write, m_address}, {1'b1, 1'b1, 15'h0804});
    #2 reset_n = 1'b0;
    #1;
    check("rst_outputs_zero", {busy, done, m_chipselect, m_write, m_address, m_byteenable, m_writedata}, '0);
`ifdef ONCHIP_MEM_DMA_CHECKSUM_EN
    check("rst_checksum_zero", checksum, 32'h0);
`endif
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_hold_quiet", {busy, done, m_chipselect}, 3'b000);
    end
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_release_idle", {busy, done, m_chipselect}, 3'b000);
    for (int i = 0; i < 32768; i++) model[i] = mem[i];
    run_cmd(1'b0, 15'h0, 15'h0900, 16'd1, $urandom, 1'b0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
